// File: rtl/mlp_param_loader.sv
// mlp_param_loader: unpacks one serial valid/ready word stream into the parallel
// weight, bias and input arrays of the single-neuron MLP datapath, then issues the
// init / initial_flag / weight_flag controls and holds off until neuron_done.
// Optional feature macro: LOADER_CKSUM_EN (trailing XOR checksum word, sticky err).
module mlp_param_loader #(
   parameter int M  = 2,
   parameter int N  = 2,
   parameter int QM = 3,
   parameter int QN = 5,
   parameter int WM = 3,
   parameter int WN = 5
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  mode_full,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   input  logic signed [QM+QN-1:0]               s_data,
   input  logic                                  neuron_done,
   output logic [N-1:0][QM+QN-1:0]               x,
   output logic [M-2:0][N-1:0][N-1:0][WM+WN-1:0] w,
   output logic [M-2:0][N-1:0][QM+QN-1:0]        b,
   output logic                                  init,
   output logic                                  initial_flag,
   output logic                                  weight_flag,
   output logic                                  busy,
   output logic                                  err
);

   localparam int DW  = QM + QN;
   localparam int WW  = WM + WN;
   localparam int NW  = (M - 1) * N * N;
   localparam int NB  = (M - 1) * N;
   localparam int NX  = N;
   // NW is always the largest count, so one counter width covers all three phases
   localparam int WIW = (NW > 1) ? $clog2(NW) : 1;
   localparam int BIW = (NB > 1) ? $clog2(NB) : 1;
   localparam int XIW = (NX > 1) ? $clog2(NX) : 1;
   localparam int CW  = WIW;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_W = 3'd1;
   localparam logic [2:0] S_LOAD_B = 3'd2;
   localparam logic [2:0] S_LOAD_X = 3'd3;
   localparam logic [2:0] S_START  = 3'd5;
   localparam logic [2:0] S_RUN    = 3'd6;
`ifdef LOADER_CKSUM_EN
   localparam logic [2:0] S_CHECK  = 3'd4;
`endif

   if (WW > DW) begin : g_width_chk
      $error("mlp_param_loader: WM+WN must not exceed QM+QN");
   end

   logic [2:0]              state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [NW-1:0][WW-1:0]   w_q, w_d;
   logic [NB-1:0][DW-1:0]   b_q, b_d;
   logic [NX-1:0][DW-1:0]   x_q, x_d;
   logic                    full_q, full_d;
   logic                    init_q, init_d;
   logic                    initf_q, initf_d;
   logic                    wflag_q, wflag_d;
   logic                    busy_q, busy_d;
   logic                    ready_q, ready_d;
`ifdef LOADER_CKSUM_EN
   logic [DW-1:0]           cksum_q, cksum_d;
   logic                    err_q, err_d;
`endif

   logic                    accept_s;
   logic                    go_x_done_s;
   logic                    go_start_s;
   logic [WIW-1:0]          w_idx_s;
   logic [BIW-1:0]          b_idx_s;
   logic [XIW-1:0]          x_idx_s;

   assign accept_s = s_valid & ready_q;
   assign w_idx_s  = cnt_q[WIW-1:0];
   assign b_idx_s  = cnt_q[BIW-1:0];
   assign x_idx_s  = cnt_q[XIW-1:0];

   // Next-state, array-write and control-pulse logic for the load sequencer
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      w_d         = w_q;
      b_d         = b_q;
      x_d         = x_q;
      full_d      = full_q;
      init_d      = 1'b0;
      initf_d     = 1'b0;
      wflag_d     = wflag_q;
      busy_d      = busy_q;
      go_x_done_s = 1'b0;
      go_start_s  = 1'b0;
`ifdef LOADER_CKSUM_EN
      err_d       = err_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               if (mode_full) begin
                  // new weights invalidate the old set immediately
                  full_d  = 1'b1;
                  wflag_d = 1'b0;
                  busy_d  = 1'b1;
                  w_d[0]  = s_data[WW-1:0];
                  if (NW == 1) begin
                     state_d = S_LOAD_B;
                     cnt_d   = CW'(0);
                  end else begin
                     state_d = S_LOAD_W;
                     cnt_d   = CW'(1);
                  end
               end else if (wflag_q) begin
                  full_d = 1'b0;
                  busy_d = 1'b1;
                  x_d[0] = s_data;
                  if (NX == 1) begin
                     go_x_done_s = 1'b1;
                     cnt_d       = CW'(0);
                  end else begin
                     state_d = S_LOAD_X;
                     cnt_d   = CW'(1);
                  end
               end else begin
                  // x-only sample without stored weights cannot run: drop it
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD_W: begin
            if (accept_s) begin
               w_d[w_idx_s] = s_data[WW-1:0];
               if (cnt_q == CW'(NW - 1)) begin
                  state_d = S_LOAD_B;
                  cnt_d   = CW'(0);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               state_d = S_LOAD_W;
            end
         end
         S_LOAD_B: begin
            if (accept_s) begin
               b_d[b_idx_s] = s_data;
               if (cnt_q == CW'(NB - 1)) begin
                  state_d = S_LOAD_X;
                  cnt_d   = CW'(0);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               state_d = S_LOAD_B;
            end
         end
         S_LOAD_X: begin
            if (accept_s) begin
               x_d[x_idx_s] = s_data;
               if (cnt_q == CW'(NX - 1)) begin
                  go_x_done_s = 1'b1;
                  cnt_d       = CW'(0);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               state_d = S_LOAD_X;
            end
         end
`ifdef LOADER_CKSUM_EN
         S_CHECK: begin
            if (accept_s) begin
               if (s_data == cksum_q) begin
                  go_start_s = 1'b1;
               end else begin
                  err_d   = 1'b1;
                  wflag_d = 1'b0;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_CHECK;
            end
         end
`endif
         S_START: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (neuron_done) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (go_x_done_s) begin
`ifdef LOADER_CKSUM_EN
         state_d = S_CHECK;
`else
         go_start_s = 1'b1;
`endif
      end else begin
         go_start_s = go_start_s;
      end

      // init and initial_flag are registered so they appear in the START cycle
      if (go_start_s) begin
         state_d = S_START;
         init_d  = 1'b1;
         initf_d = full_d;
         if (full_d) begin
            wflag_d = 1'b1;
         end else begin
            wflag_d = wflag_q;
         end
      end else begin
         init_d = 1'b0;
      end

      ready_d = (state_d == S_IDLE)   || (state_d == S_LOAD_W) ||
                (state_d == S_LOAD_B) || (state_d == S_LOAD_X)
`ifdef LOADER_CKSUM_EN
                || (state_d == S_CHECK)
`endif
                ;
   end

`ifdef LOADER_CKSUM_EN
   // Running XOR of payload words; restarts on the first word of every load
   always_comb begin
      if (accept_s && (state_q == S_IDLE)) begin
         cksum_d = s_data;
      end else if (accept_s && ((state_q == S_LOAD_W) || (state_q == S_LOAD_B) ||
                                (state_q == S_LOAD_X))) begin
         cksum_d = cksum_q ^ s_data;
      end else begin
         cksum_d = cksum_q;
      end
   end
`endif

   // State and output registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= CW'(0);
         w_q     <= '{default: {WW{1'b0}}};
         b_q     <= '{default: {DW{1'b0}}};
         x_q     <= '{default: {DW{1'b0}}};
         full_q  <= 1'b0;
         init_q  <= 1'b0;
         initf_q <= 1'b0;
         wflag_q <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
`ifdef LOADER_CKSUM_EN
         cksum_q <= {DW{1'b0}};
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         w_q     <= w_d;
         b_q     <= b_d;
         x_q     <= x_d;
         full_q  <= full_d;
         init_q  <= init_d;
         initf_q <= initf_d;
         wflag_q <= wflag_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
`ifdef LOADER_CKSUM_EN
         cksum_q <= cksum_d;
         err_q   <= err_d;
`endif
      end
   end

   assign s_ready      = ready_q;
   assign w            = w_q;
   assign b            = b_q;
   assign x            = x_q;
   assign init         = init_q;
   assign initial_flag = initf_q;
   assign weight_flag  = wflag_q;
   assign busy         = busy_q;
`ifdef LOADER_CKSUM_EN
   assign err          = err_q;
`else
   assign err          = 1'b0;
`endif

endmodule
